// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM capture block and the
// matching PWM generator. The generator encodes a LVL_BITS-wide level as a
// high time of level*PWM_LVL_STEP + PWM_HALF_STEP inside a PWM_FRAME frame.
package pwm_pkg;

    // Default measurement counter width; nominal frame is 2**PWM_CBITS cycles.
    localparam int PWM_CBITS    = 15;
    // Default decoded level width.
    localparam int PWM_LVL_BITS = 4;
    // Default glitch-filter depth (cycles), used only when the filter is built.
    localparam int PWM_FILT_LEN = 4;

    // Generator frame length in clk cycles.
    localparam int PWM_FRAME     = 2 ** PWM_CBITS;
    // One level step of high time (2048 at the defaults).
    localparam int PWM_LVL_STEP  = PWM_FRAME >> PWM_LVL_BITS;
    // Half-step offset that centres each level inside its decode bin (1024).
    localparam int PWM_HALF_STEP = PWM_LVL_STEP / 2;

    // Capture FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_cap_state_e;

    // High time the generator produces for a given level.
    function automatic int pwm_high_time(input int lvl);
        return (lvl * PWM_LVL_STEP) + PWM_HALF_STEP;
    endfunction

endpackage

// File: rtl/pwm_in_cond.sv
// pwm_in_cond: brings the asynchronous PWM input into the clk domain through a
// 2-flop synchronizer and, when PWM_CAP_GLITCH_FILTER_EN is defined, a glitch
// filter that only follows the synchronized input after it has held a new
// value for FILT_LEN consecutive cycles. Without the macro pwm_s is the
// synchronizer output.
module pwm_in_cond
    import pwm_pkg::*;
#(
    parameter int FILT_LEN = PWM_FILT_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic pwm_s
);

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    // Effective depth: zero means the filter is not elaborated at all.
    localparam int FILT_EFF = (FILT_ON && (FILT_LEN > 0)) ? FILT_LEN : 0;

    logic sync1_r;
    logic sync2_r;

    // Two-flop synchronizer for the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (FILT_EFF > 0) begin : g_filt
            localparam int FW = (FILT_EFF > 1) ? $clog2(FILT_EFF) : 1;
            localparam logic [FW-1:0] CNT_LAST = FW'(FILT_EFF - 1);

            logic [FW-1:0] cnt_r;
            logic          filt_r;

            // Count cycles the synchronized input disagrees with the filtered
            // level; flip once the disagreement has lasted FILT_LEN cycles.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_r  <= '0;
                    filt_r <= 1'b0;
                end else if (sync2_r == filt_r) begin
                    cnt_r  <= '0;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_r  <= '0;
                    filt_r <= sync2_r;
                end else begin
                    cnt_r  <= cnt_r + FW'(1);
                end
            end

            assign pwm_s = filt_r;
        end else begin : g_pass
            assign pwm_s = sync2_r;
        end
    endgenerate

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period (in clk cycles) of a PWM input and
// decodes the duty level from the top bits of the high time. A measurement is
// published as a one-cycle meas_valid pulse at each rising edge that closes a
// complete frame; the first frame after reset or after a stuck line only
// aligns. A line with no rising edge for a full frame raises stuck.
// Optional feature macro: PWM_CAP_GLITCH_FILTER_EN (input glitch filter).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CBITS    = PWM_CBITS,
    parameter int LVL_BITS = PWM_LVL_BITS,
    parameter int FILT_LEN = PWM_FILT_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_in,
    output logic                meas_valid,
    output logic [CBITS-1:0]    high_cnt,
    output logic [CBITS-1:0]    period_cnt,
    output logic [LVL_BITS-1:0] level,
    output logic                stuck,
    output logic                stuck_high
);

    localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);
    localparam logic [CBITS-1:0] CNT_MAX = {CBITS{1'b1}};

    logic pwm_s;
    logic pwm_q_r;
    logic rise_s;
    logic fall_s;

    pwm_cap_state_e state_r;
    pwm_cap_state_e state_nxt_s;

    logic [CBITS-1:0] hc_r;
    logic [CBITS-1:0] pc_r;
    logic [CBITS-1:0] hc_nxt_s;
    logic [CBITS-1:0] pc_nxt_s;
    logic [CBITS-1:0] hc_inc_s;
    logic [CBITS-1:0] pc_inc_s;
    // pc has already sat at all-ones for a whole cycle: a generator frame of
    // exactly 2**CBITS cycles still closes on the next edge, so the line is
    // only declared stuck one cycle later than the counter saturates.
    logic             pc_sat_r;
    logic             pc_sat_nxt_s;
    logic             publish_s;
    logic             stuck_set_s;

    logic                meas_valid_r;
    logic [CBITS-1:0]    high_cnt_r;
    logic [CBITS-1:0]    period_cnt_r;
    logic [LVL_BITS-1:0] level_r;
    logic                stuck_r;
    logic                stuck_high_r;

    pwm_in_cond #(
        .FILT_LEN (FILT_LEN)
    ) u_in_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .pwm_s  (pwm_s)
    );

    // One-cycle delayed copy of the conditioned input for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q_r <= 1'b0;
        end else begin
            pwm_q_r <= pwm_s;
        end
    end

    assign rise_s = pwm_s & ~pwm_q_r;
    assign fall_s = ~pwm_s & pwm_q_r;

    // Saturating increments of both counters.
    always_comb begin
        hc_inc_s = (hc_r == CNT_MAX) ? hc_r : (hc_r + CNT_ONE);
        pc_inc_s = (pc_r == CNT_MAX) ? pc_r : (pc_r + CNT_ONE);
    end

    // Next-state, counter updates and publish/stuck decisions.
    always_comb begin
        state_nxt_s  = state_r;
        hc_nxt_s     = hc_r;
        pc_nxt_s     = pc_r;
        pc_sat_nxt_s = pc_sat_r;
        publish_s    = 1'b0;
        stuck_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s  = HIGH;
                    hc_nxt_s     = CNT_ONE;
                    pc_nxt_s     = CNT_ONE;
                    pc_sat_nxt_s = 1'b0;
                end else begin
                    pc_sat_nxt_s = 1'b0;
                end
            end
            HIGH: begin
                if (fall_s) begin
                    state_nxt_s  = LOW;
                    pc_nxt_s     = pc_inc_s;
                    pc_sat_nxt_s = (pc_r == CNT_MAX);
                end else if (pc_sat_r) begin
                    state_nxt_s  = IDLE;
                    stuck_set_s  = 1'b1;
                    pc_sat_nxt_s = 1'b0;
                end else begin
                    hc_nxt_s     = hc_inc_s;
                    pc_nxt_s     = pc_inc_s;
                    pc_sat_nxt_s = (pc_r == CNT_MAX);
                end
            end
            LOW: begin
                if (rise_s) begin
                    state_nxt_s  = HIGH;
                    publish_s    = 1'b1;
                    hc_nxt_s     = CNT_ONE;
                    pc_nxt_s     = CNT_ONE;
                    pc_sat_nxt_s = 1'b0;
                end else if (pc_sat_r) begin
                    state_nxt_s  = IDLE;
                    stuck_set_s  = 1'b1;
                    pc_sat_nxt_s = 1'b0;
                end else begin
                    pc_nxt_s     = pc_inc_s;
                    pc_sat_nxt_s = (pc_r == CNT_MAX);
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                hc_nxt_s     = '0;
                pc_nxt_s     = '0;
                pc_sat_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state and measurement counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            hc_r     <= '0;
            pc_r     <= '0;
            pc_sat_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            hc_r     <= hc_nxt_s;
            pc_r     <= pc_nxt_s;
            pc_sat_r <= pc_sat_nxt_s;
        end
    end

    // Registered measurement record and stuck flags; held between publishes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_valid_r <= 1'b0;
            high_cnt_r   <= '0;
            period_cnt_r <= '0;
            level_r      <= '0;
            stuck_r      <= 1'b0;
            stuck_high_r <= 1'b0;
        end else begin
            meas_valid_r <= publish_s;
            if (publish_s) begin
                high_cnt_r   <= hc_r;
                period_cnt_r <= pc_r;
                level_r      <= hc_r[CBITS-1 -: LVL_BITS];
                stuck_r      <= 1'b0;
                stuck_high_r <= 1'b0;
            end else if (stuck_set_s) begin
                stuck_r      <= 1'b1;
                stuck_high_r <= pwm_s;
            end else begin
                stuck_r      <= stuck_r;
                stuck_high_r <= stuck_high_r;
            end
        end
    end

    assign meas_valid = meas_valid_r;
    assign high_cnt   = high_cnt_r;
    assign period_cnt = period_cnt_r;
    assign level      = level_r;
    assign stuck      = stuck_r;
    assign stuck_high = stuck_high_r;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture. The DUT runs with
// CBITS=10 so frames are 1024 cycles; generator encoding scales to
// high = level*64 + 32, and a 1024-cycle period saturates to 1023.
module tb_pwm_capture;

    localparam int CB = 10;
    localparam int LB = 4;
    localparam int FL = 4;
`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int LAT = 3 + FL;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic          meas_valid;
    logic [CB-1:0] high_cnt;
    logic [CB-1:0] period_cnt;
    logic [LB-1:0] level;
    logic          stuck;
    logic          stuck_high;

    pwm_capture #(
        .CBITS    (CB),
        .LVL_BITS (LB),
        .FILT_LEN (FL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .meas_valid (meas_valid),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .level      (level),
        .stuck      (stuck),
        .stuck_high (stuck_high)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int p;
        int lv;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input int h, input int p, input int lv, input int st);
        exp_t e;
        e.h  = h;
        e.p  = p;
        e.lv = lv;
        e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    // Level-9 frame (high 608) with a 2-cycle low glitch 300 cycles in.
    task automatic gframe();
        drive(1'b1, 300);
        drive(1'b0, 2);
`ifndef PWM_CAP_GLITCH_FILTER_EN
        push(300, 302, 4, 0);
`endif
        drive(1'b1, 306);
        drive(1'b0, 416);
    endtask

    // Expected record closed by the rise after a glitched frame.
    task automatic push_gend();
`ifdef PWM_CAP_GLITCH_FILTER_EN
        push(608, 1023, 9, 0);
`else
        push(306, 722, 4, 0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_high_cnt"}, high_cnt, 0);
        check({tag, "_period_cnt"}, period_cnt, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_stuck"}, stuck, 0);
        check({tag, "_stuck_high"}, stuck_high, 0);
    endtask

    // Monitor: every meas_valid pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_meas: got meas_valid high_cnt=%0d period_cnt=%0d, expected none at %0t",
                         high_cnt, period_cnt, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("meas_high_cnt", high_cnt, e.h);
                check("meas_period_cnt", period_cnt, e.p);
                check("meas_level", level, e.lv);
                check("meas_stuck", stuck, e.st);
            end
        end
    end

    initial begin
        int lat;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        drive(1'b0, 5);

        // Level 5 frames: first rise aligns only.
        frame(352, 672);
        push(352, 1023, 5, 0);
        frame(352, 672);
        push(352, 1023, 5, 0);
        // Level 0 then level 15 frames.
        frame(32, 992);
        push(32, 1023, 0, 0);
        frame(32, 992);
        push(32, 1023, 0, 0);
        frame(992, 32);
        push(992, 1023, 15, 0);
        frame(992, 32);
        push(992, 1023, 15, 0);

        // Stuck high: rise then hold.
        drive(1'b1, 1000);
        check("stuck_early", stuck, 0);
        drive(1'b1, 300);
        check("stuck_set", stuck, 1);
        check("stuck_high_set", stuck_high, 1);
        drive(1'b0, 50);
        check("stuck_held", stuck, 1);
        frame(10, 6);
        check("stuck_after_first_rise", stuck, 1);

        // Short frame, with latency from the input rise to meas_valid.
        push(10, 16, 0, 0);
        pwm_in = 1'b1;
        lat = 0;
        while (meas_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, LAT);
        if (lat < 10) drive(1'b1, 10 - lat);
        drive(1'b0, 6);
        push(10, 16, 0, 0);

        // Glitched level-9 frames.
        gframe();
        push_gend();
        gframe();
        push_gend();
        drive(1'b1, 50);

        // One-cycle reset in the middle of a high phase.
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        drive(1'b0, 20);
        frame(10, 6);
        push(10, 16, 0, 0);
        frame(10, 6);
        push(10, 16, 0, 0);
        drive(1'b1, 10);
        drive(1'b0, 10);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
